// File: rtl/sys_defs.sv
// Shared machine-wide constants and the common data bus packet.
package sys_defs;
  localparam int NUM_FU = 4;
  localparam int XLEN   = 32;
  localparam int TAG_W  = 5;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  value;
  } cdb_pkt_t;
endpackage

// File: rtl/cdb_arb_rr_picker.sv
// Round-robin picker: first requester found scanning ptr, ptr+1, ... mod N.
module rr_picker #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] win
);
  logic [PW:0]   sum;
  logic [PW-1:0] idx;

  // Scan from the far end so the offset closest to ptr overwrites last.
  always_comb begin
    gnt = '0;
    win = '0;
    sum = '0;
    idx = '0;
    for (int off = N-1; off >= 0; off--) begin
      sum = {1'b0, ptr} + (PW+1)'(off);
      if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
      idx = sum[PW-1:0];
      if (req[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
        win      = idx;
      end
    end
  end
endmodule

// File: rtl/cdb_arb.sv
// CDB arbiter: round-robin grant among FUs, one registered broadcast per cycle.
module cdb_arb
  import sys_defs::cdb_pkt_t;
#(
  parameter int NUM_FU = sys_defs::NUM_FU,
  parameter int XLEN   = sys_defs::XLEN,
  parameter int TAG_W  = sys_defs::TAG_W
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          squash,
  input  logic [NUM_FU-1:0]             fu_done,
  input  logic [NUM_FU-1:0][TAG_W-1:0]  fu_tag,
  input  logic [NUM_FU-1:0][XLEN-1:0]   fu_result,
  output logic [NUM_FU-1:0]             fu_ack,
  output logic                          cdb_valid,
  output logic [TAG_W-1:0]              cdb_tag,
  output logic [XLEN-1:0]               cdb_value
);
  localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  logic [PTR_W-1:0]  ptr_q, ptr_d;
  cdb_pkt_t          pkt_q, pkt_d;
  logic [NUM_FU-1:0] req_eff, gnt;
  logic [PTR_W-1:0]  win;

  // Reset and squash both mask requests so no ack leaks out.
  assign req_eff = (reset && !squash) ? fu_done : '0;

  rr_picker #(.N(NUM_FU), .PW(PTR_W)) u_pick (
    .req (req_eff),
    .ptr (ptr_q),
    .gnt (gnt),
    .win (win)
  );

  always_comb begin
    ptr_d       = ptr_q;
    pkt_d       = pkt_q;
    pkt_d.valid = 1'b0;
    if (|gnt) begin
      ptr_d       = (win == PTR_W'(NUM_FU-1)) ? '0 : win + 1'b1;
      pkt_d.valid = 1'b1;
      pkt_d.tag   = fu_tag[win];
      pkt_d.value = fu_result[win];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      ptr_q <= '0;
      pkt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      pkt_q <= pkt_d;
    end
  end

  assign fu_ack    = gnt;
  assign cdb_valid = pkt_q.valid;
  assign cdb_tag   = pkt_q.tag;
  assign cdb_value = pkt_q.value;
endmodule
